// File: rtl/corescore_stream_arb_if.sv
// Stream bundle between NUM_PORTS byte sources, the shared arbiter and its sink.
// The "slave" modport is the arbiter's view; "master" is the environment driving it.
interface corescore_stream_arb_if #(
  parameter int NUM_PORTS = 4
);
  logic [8*NUM_PORTS-1:0] i_tdata;
  logic [NUM_PORTS-1:0]   i_tlast;
  logic [NUM_PORTS-1:0]   i_tvalid;
  logic [NUM_PORTS-1:0]   o_tready;
  logic [7:0]             o_tdata;
  logic                   o_tlast;
  logic                   o_tvalid;
  logic                   i_tready;
  logic [NUM_PORTS-1:0]   o_grant;
  logic                   o_wdt;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, i_tready,
    output o_tready, o_tdata, o_tlast, o_tvalid, o_grant, o_wdt
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, i_tready,
    input  o_tready, o_tdata, o_tlast, o_tvalid, o_grant, o_wdt
  );
endinterface

// File: rtl/corescore_stream_arb.sv
// Packet-level round-robin arbiter sharing one byte-stream sink between
// NUM_PORTS sources. A grant is held until the granted source's tlast beat is
// accepted; bytes pass through a single output register.
// Optional watchdog: define CORESCORE_ARB_WDT_EN to terminate a packet whose
// source stalls for WDT_CYCLES cycles, inject TERM_BYTE with tlast and discard
// the rest of that packet.
module corescore_stream_arb #(
  parameter int         NUM_PORTS  = 4,
  parameter int         WDT_CYCLES = 1024,
  parameter logic [7:0] TERM_BYTE  = 8'h0A
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  corescore_stream_arb_if.slave  bus
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1
`ifdef CORESCORE_ARB_WDT_EN
    ,
    ST_DROP = 2'd2
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [7:0]           tdata_q, tdata_d;
  logic                 tlast_q, tlast_d;
  logic                 tvalid_q, tvalid_d;

`ifdef CORESCORE_ARB_WDT_EN
  localparam int CW = $clog2(WDT_CYCLES + 1);
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 wdt_q, wdt_d;
`else
  // Watchdog parameters have no effect in this build.
  logic unused_cfg;
  assign unused_cfg = ^{WDT_CYCLES, TERM_BYTE};
`endif

  logic [7:0]           port_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] src_ready;
  logic                 src_valid;
  logic                 src_last;
  logic [7:0]           src_data;
  logic                 out_free;
  logic                 pick_found;
  logic [IW-1:0]        pick_idx;

  // Split the packed data bus into per-port bytes.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign port_data[gi] = bus.i_tdata[8*gi +: 8];
  end

  // The output register can take a new beat when empty or draining this cycle.
  assign out_free  = !tvalid_q || bus.i_tready;
  assign src_valid = bus.i_tvalid[gidx_q];
  assign src_last  = bus.i_tlast[gidx_q];
  assign src_data  = port_data[gidx_q];

  // Round-robin search: first requester above the last-served port, wrapping.
  always_comb begin
    int cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = (int'(ptr_q) + off) % NUM_PORTS;
      if (!pick_found && bus.i_tvalid[IW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  // Next-state, grant, output-register and source-ready logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    tvalid_d  = tvalid_q && !bus.i_tready;
    src_ready = '0;
`ifdef CORESCORE_ARB_WDT_EN
    cnt_d     = cnt_q;
    wdt_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // No beat is taken in IDLE; the grant becomes visible next cycle.
        if (pick_found) begin
          gidx_d  = pick_idx;
          grant_d = NUM_PORTS'(1) << pick_idx;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        src_ready = grant_q & {NUM_PORTS{out_free}};
        if (src_valid && out_free) begin
          tdata_d  = src_data;
          tlast_d  = src_last;
          tvalid_d = 1'b1;
`ifdef CORESCORE_ARB_WDT_EN
          cnt_d    = '0;
`endif
          if (src_last) begin
            ptr_d   = gidx_q;
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end
`ifdef CORESCORE_ARB_WDT_EN
        else if (cnt_q == CW'(WDT_CYCLES)) begin
          // Expired: close the packet on the sink as soon as the register frees.
          if (out_free) begin
            tdata_d  = TERM_BYTE;
            tlast_d  = 1'b1;
            tvalid_d = 1'b1;
            wdt_d    = 1'b1;
            cnt_d    = '0;
            state_d  = ST_DROP;
          end
        end else if (!src_valid) begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
`ifdef CORESCORE_ARB_WDT_EN
      ST_DROP: begin
        // Swallow the remainder of the stalled packet without touching the sink.
        src_ready = grant_q;
        if (src_valid && src_last) begin
          ptr_d   = gidx_q;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset makes port 0 the first winner.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= IW'(NUM_PORTS - 1);
      gidx_q   <= '0;
      grant_q  <= '0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
`ifdef CORESCORE_ARB_WDT_EN
      cnt_q    <= '0;
      wdt_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
`ifdef CORESCORE_ARB_WDT_EN
      cnt_q    <= cnt_d;
      wdt_q    <= wdt_d;
`endif
    end
  end

  assign bus.o_tready = src_ready;
  assign bus.o_tdata  = tdata_q;
  assign bus.o_tlast  = tlast_q;
  assign bus.o_tvalid = tvalid_q;
  assign bus.o_grant  = grant_q;
`ifdef CORESCORE_ARB_WDT_EN
  assign bus.o_wdt    = wdt_q;
`else
  assign bus.o_wdt    = 1'b0;
`endif

endmodule

// File: tb/tb_corescore_stream_arb.sv
// Bench for corescore_stream_arb: directed packet scenarios, a cycle model of
// the arbitration/output-register rules checked every cycle, and literal
// expectations on the resulting sink byte streams.
module tb_corescore_stream_arb;
  localparam int         NP   = 4;
  localparam int         WDT  = 8;
  localparam logic [7:0] TERM = 8'h0A;
  localparam logic [9:0] GAP  = 10'h200;  // source entry: valid low for one cycle

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  corescore_stream_arb_if #(.NUM_PORTS(NP)) bus ();

  corescore_stream_arb #(
    .NUM_PORTS (NP),
    .WDT_CYCLES(WDT),
    .TERM_BYTE (TERM)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int rdy_mode   = 0;
  int wdt_pulses = 0;

  logic [9:0] src_q [NP][$];   // per port: {gap, last, data}
  logic [8:0] snk_log [$];     // sink beats: {last, data}
  int         snk_cyc [$];
  logic [8:0] exp_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_inputs();
    logic [NP-1:0]   v;
    logic [NP-1:0]   l;
    logic [8*NP-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int k = 0; k < NP; k++) begin
      if (src_q[k].size() > 0 && !src_q[k][0][9]) begin
        v[k]        = 1'b1;
        l[k]        = src_q[k][0][8];
        d[8*k +: 8] = src_q[k][0][7:0];
      end
    end
    bus.i_tvalid = v;
    bus.i_tlast  = l;
    bus.i_tdata  = d;
    bus.i_tready = (rdy_mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
  endtask

  // One clock: sample handshakes mid-cycle, update sources just after the edge.
  task automatic step();
    logic [NP-1:0] acc;
    logic          sacc;
    logic [8:0]    sbeat;
    @(negedge clk);
    acc   = bus.i_tvalid & bus.o_tready;
    sacc  = bus.o_tvalid & bus.i_tready;
    sbeat = {bus.o_tlast, bus.o_tdata};
    if (bus.o_wdt) wdt_pulses++;
    @(posedge clk);
    #1;
    if (rst_n) begin
      for (int k = 0; k < NP; k++) begin
        if (src_q[k].size() > 0 && (acc[k] || src_q[k][0][9]))
          void'(src_q[k].pop_front());
      end
      if (sacc) begin
        snk_log.push_back(sbeat);
        snk_cyc.push_back(cyc);
        $display("sink beat cycle=%0d data=%02h last=%0b", cyc, sbeat[7:0], sbeat[8]);
      end
    end
    cyc++;
    drive_inputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NP; k++) src_q[k].delete();
    snk_log.delete();
    snk_cyc.delete();
    wdt_pulses = 0;
    cyc        = 0;
    rdy_mode   = 0;
    drive_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic expect_beat(input logic [8:0] b);
    exp_log.push_back(b);
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, 32'(snk_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++)
      chk($sformatf("%s_beat%0d", name, i),
          (i < snk_log.size()) ? 32'(snk_log[i]) : 32'hFFFF_FFFF, 32'(exp_log[i]));
    exp_log.delete();
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_grant"},  32'(bus.o_grant),  32'h0);
    chk({name, "_tready"}, 32'(bus.o_tready), 32'h0);
    chk({name, "_tvalid"}, 32'(bus.o_tvalid), 32'h0);
    chk({name, "_tdata"},  32'(bus.o_tdata),  32'h0);
    chk({name, "_tlast"},  32'(bus.o_tlast),  32'h0);
    chk({name, "_wdt"},    32'(bus.o_wdt),    32'h0);
  endtask

  // ---------------- behavioural model, checked every cycle ----------------
  int         m_gnt;   // granted port, -1 when idle
  int         m_ptr;   // last served port
  int         m_stall;
  bit         m_outv;
  bit         m_outl;
  bit         m_wdt;
  bit         m_drop;
  logic [7:0] m_outd;

  always @(negedge clk) begin
    int            g;
    logic [NP-1:0] v;
    logic [NP-1:0] l;
    logic          free;
    logic [31:0]   e_rdy;
    if (!rst_n) begin
      m_gnt   = -1;
      m_ptr   = NP - 1;
      m_stall = 0;
      m_outv  = 0;
      m_outl  = 0;
      m_wdt   = 0;
      m_drop  = 0;
      m_outd  = 8'h00;
    end else begin
      v = bus.i_tvalid;
      l = bus.i_tlast;
      g = m_gnt;
      if (g < 0) e_rdy = 32'h0;
      else if (m_drop || !m_outv || bus.i_tready) e_rdy = 32'(1) << g;
      else e_rdy = 32'h0;
      chk("grant",  32'(bus.o_grant),  (g < 0) ? 32'h0 : (32'(1) << g));
      chk("tready", 32'(bus.o_tready), e_rdy);
      chk("tvalid", 32'(bus.o_tvalid), 32'(m_outv));
      chk("tdata",  32'(bus.o_tdata),  32'(m_outd));
      chk("tlast",  32'(bus.o_tlast),  32'(m_outl));
      chk("wdt",    32'(bus.o_wdt),    32'(m_wdt));

      free  = !m_outv || bus.i_tready;
      m_wdt = 0;
      if (m_outv && bus.i_tready) m_outv = 0;
      if (g < 0) begin
        for (int off = 1; off <= NP; off++)
          if (m_gnt < 0 && v[(m_ptr + off) % NP]) m_gnt = (m_ptr + off) % NP;
      end else if (m_drop) begin
        if (v[g] && l[g]) begin
          m_ptr  = g;
          m_gnt  = -1;
          m_drop = 0;
        end
      end else if (v[g] && free) begin
        m_outv  = 1;
        m_outd  = bus.i_tdata[8*g +: 8];
        m_outl  = l[g];
        m_stall = 0;
        if (l[g]) begin
          m_ptr = g;
          m_gnt = -1;
        end
      end
`ifdef CORESCORE_ARB_WDT_EN
      else if (m_stall == WDT) begin
        if (free) begin
          m_outv  = 1;
          m_outd  = TERM;
          m_outl  = 1;
          m_wdt   = 1;
          m_drop  = 1;
          m_stall = 0;
        end
      end else if (!v[g]) begin
        m_stall++;
      end
`endif
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    // Reset values.
    do_reset();
    check_zero_outputs("reset");

    // Port 0 sends 41,42,43(last) with the sink always ready.
    src_q[0].push_back(10'h041);
    src_q[0].push_back(10'h042);
    src_q[0].push_back(10'h143);
    drive_inputs();
    step();
    chk("t1_grant",      32'(bus.o_grant),  32'h1);
    chk("t1_tvalid_n1",  32'(bus.o_tvalid), 32'h0);
    chk("t1_tready_n1",  32'(bus.o_tready), 32'h1);
    step();
    chk("t1_tvalid_n2",  32'(bus.o_tvalid), 32'h1);
    chk("t1_first_data", 32'(bus.o_tdata),  32'h41);
    run(8);
    if (snk_cyc.size() == 3)
      chk("t1_consecutive", 32'(snk_cyc[2] - snk_cyc[0]), 32'd2);
    expect_beat(9'h041);
    expect_beat(9'h042);
    expect_beat(9'h143);
    check_log("t1");

    // All four ports request 1-byte packets continuously.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NP; k++) src_q[k].push_back(10'h100 | 10'(k));
    drive_inputs();
    run(24);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NP; k++) expect_beat(9'h100 | 9'(k));
    check_log("t2");

    // Port 2 sends 4 bytes while the sink ready toggles 1,0,0,1.
    do_reset();
    rdy_mode = 1;
    src_q[2].push_back(10'h021);
    src_q[2].push_back(10'h022);
    src_q[2].push_back(10'h023);
    src_q[2].push_back(10'h124);
    drive_inputs();
    run(30);
    expect_beat(9'h021);
    expect_beat(9'h022);
    expect_beat(9'h023);
    expect_beat(9'h124);
    check_log("t3");

    // Asynchronous reset in the middle of a packet on port 1.
    do_reset();
    for (int b = 1; b <= 6; b++) src_q[1].push_back(((b == 6) ? 10'h100 : 10'h000) | 10'(8'h60 + b));
    drive_inputs();
    run(3);
    chk("t4_pre_grant",  32'(bus.o_grant),  32'h2);
    chk("t4_pre_tvalid", 32'(bus.o_tvalid), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("t4_async");
    do_reset();
    src_q[0].push_back(10'h130);
    src_q[1].push_back(10'h131);
    drive_inputs();
    step();
    chk("t4_regrant", 32'(bus.o_grant), 32'h1);
    run(8);
    expect_beat(9'h130);
    expect_beat(9'h131);
    check_log("t4");

    // Port 3 stalls mid-packet, then finishes with 55(last); port 0 waits.
    do_reset();
    src_q[3].push_back(10'h011);
    src_q[3].push_back(10'h022);
    for (int i = 0; i < 12; i++) src_q[3].push_back(GAP);
    src_q[3].push_back(10'h155);
    drive_inputs();
    step();
    chk("t5_grant", 32'(bus.o_grant), 32'h8);
    src_q[0].push_back(10'h1F0);
    drive_inputs();
    run(40);
    expect_beat(9'h011);
    expect_beat(9'h022);
`ifdef CORESCORE_ARB_WDT_EN
    expect_beat({1'b1, TERM});
    chk("t5_wdt_pulses", 32'(wdt_pulses), 32'd1);
`else
    expect_beat(9'h155);
    chk("t5_wdt_pulses", 32'(wdt_pulses), 32'd0);
`endif
    expect_beat(9'h1F0);
    check_log("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
